// File: rtl/vscale_regfile_sb.sv
// Integer register file with hardwired-zero x0, a per-register pending-write scoreboard
// and a post-reset zeroing sweep. Optional write-through forwarding: VSCALE_REGFILE_BYPASS_EN.
module vscale_regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int AW     = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     ready,
    input  logic [NUM_RD*AW-1:0]     ra,
    output logic [NUM_RD*XLEN-1:0]   rd,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic                     wen,
    input  logic [AW-1:0]            wa,
    input  logic [XLEN-1:0]          wd,
    input  logic                     alloc_en,
    input  logic [AW-1:0]            alloc_addr,
    input  logic                     flush
);

    localparam int DEPTH = 2 ** AW;

`ifndef SYNTHESIS
    if (NREGS > DEPTH) begin : g_chk_nregs
        $fatal(1, "vscale_regfile_sb: NREGS exceeds 2**AW");
    end
    if (NUM_RD < 1 || NUM_RD > 4) begin : g_chk_num_rd
        $fatal(1, "vscale_regfile_sb: NUM_RD must be 1..4");
    end
`endif

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t            state_reg;
    logic [AW-1:0]     sweep_reg;
    logic              ready_reg;
    logic [DEPTH-1:0]  busy_reg;
    logic [DEPTH-1:0]  busy_next;
    logic [XLEN-1:0]   mem [DEPTH];
    logic              run;
    logic              wr_ok;

    // Architectural register addresses exclude x0 and anything at or above NREGS.
    function automatic logic in_range(input logic [AW-1:0] a);
        return (a != '0) && (int'(a) < NREGS);
    endfunction

    assign run   = (state_reg == ST_RUN);
    assign wr_ok = run && wen && in_range(wa);
    assign ready = ready_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_INIT;
            sweep_reg <= AW'(1);
            ready_reg <= 1'b0;
            busy_reg  <= '0;
        end else begin
            case (state_reg)
                ST_INIT: begin
                    sweep_reg <= sweep_reg + AW'(1);
                    if (sweep_reg == AW'(NREGS - 1)) begin
                        state_reg <= ST_RUN;
                        ready_reg <= 1'b1;
                    end
                end
                ST_RUN: begin
                    busy_reg <= busy_next;
                end
                default: begin
                    state_reg <= ST_INIT;
                    sweep_reg <= AW'(1);
                    ready_reg <= 1'b0;
                end
            endcase
        end
    end

    // Data array carries no reset; the sweep gives it a defined value before RUN.
    always_ff @(posedge clk) begin
        if (state_reg == ST_INIT) begin
            mem[sweep_reg] <= '0;
        end else if (wr_ok) begin
            mem[wa] <= wd;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_busy
            if (gi == 0 || gi >= NREGS) begin : g_const
                assign busy_next[gi] = 1'b0;
            end else begin : g_live
                // A fresh allocation outranks the flush and the retiring write.
                always_comb begin
                    busy_next[gi] = busy_reg[gi];
                    if (alloc_en && alloc_addr == AW'(gi)) begin
                        busy_next[gi] = 1'b1;
                    end else if (flush) begin
                        busy_next[gi] = 1'b0;
                    end else if (wen && wa == AW'(gi)) begin
                        busy_next[gi] = 1'b0;
                    end
                end
            end
        end

        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [AW-1:0] addr;
            logic          hit;

            assign addr = ra[gi*AW +: AW];
            assign hit  = run && in_range(addr);

`ifdef VSCALE_REGFILE_BYPASS_EN
            logic fwd;
            assign fwd = wr_ok && (wa == addr);
            assign rd[gi*XLEN +: XLEN] = !hit ? '0 : (fwd ? wd : mem[addr]);
            assign rbusy[gi] = hit && (fwd ? (alloc_en && alloc_addr == addr) : busy_reg[addr]);
`else
            assign rd[gi*XLEN +: XLEN] = hit ? mem[addr] : '0;
            assign rbusy[gi] = hit && busy_reg[addr];
`endif
        end
    endgenerate

endmodule
